// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the fetch back end.
//   NOP_WORD        : canonical NOP encoding {3'b111, 29'b0}
//   bundle_t        : {pc, 64-bit two-instruction bundle}; inst[63:32] is slot0
//   is_nop()        : word equals NOP_WORD
//   is_empty_bundle : both words of a bundle are NOP
// -----------------------------------------------------------------------------
package core_pkg;

    localparam logic [31:0] NOP_WORD = {3'b111, 29'b0};

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
    } bundle_t;

    function automatic logic is_nop(input logic [31:0] w);
        return (w == NOP_WORD);
    endfunction

    function automatic logic is_empty_bundle(input logic [63:0] b);
        return is_nop(b[63:32]) && is_nop(b[31:0]);
    endfunction

endpackage

// File: rtl/bundle_issue_fifo.sv
// -----------------------------------------------------------------------------
// bundle_fifo
//   Small circular FIFO of bundle_t entries with flush.
//   Parameters: DEPTH - number of entries (power of two, >= 2)
//   Ports:
//     clk, rstn  : clock, asynchronous active-low reset of pointers and count
//     push, din  : write request and entry (ignored when full unless popping)
//     pop        : remove head entry (ignored when empty)
//     flush      : empty the FIFO; dominates push and pop
//     head       : entry at the read pointer
//     count      : number of stored entries (0..DEPTH)
//     full/empty : count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module bundle_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  bundle_t                  din,
    input  logic                     pop,
    input  logic                     flush,
    output bundle_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    bundle_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees the head slot at the same edge, so a full FIFO can still
    // accept a write when it is popping.
    assign w_do_pop  = pop & ~empty & ~flush;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/bundle_issue.sv
// -----------------------------------------------------------------------------
// bundle_issue
//   Fetch back end: buffers {pc, two-instruction bundle} from fetch in a
//   bundle FIFO and issues one 32-bit instruction per cycle with its own pc.
//   Optional feature macro: SKIP_NOP_EN - when defined, NOP slots inside a
//   non-empty bundle are skipped instead of being issued.
//   Parameters: DEPTH - bundle FIFO entries (power of two, >= 2)
//   Ports:
//     clk          : clock, all state on posedge
//     rstn         : asynchronous active-low reset
//     pc_in        : bundle pc from fetch (unit = one 8-byte bundle)
//     bundle_in    : [63:32] slot0 (older), [31:0] slot1
//     branch_flag  : flush everything at this edge, drop same-cycle bundle
//     stall_in     : downstream cannot accept an instruction this cycle
//     interlock    : to fetch, hold pc and present a NOP bundle next cycle
//     inst_out     : issued instruction
//     pc_out       : {bundle_pc[30:0], slot}
//     valid_out    : inst_out/pc_out meaningful
//     overflow     : sticky, bundle arrived with FIFO full and no pop
// -----------------------------------------------------------------------------
module bundle_issue
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_in,
    input  logic [63:0] bundle_in,
    input  logic        branch_flag,
    input  logic        stall_in,
    output logic        interlock,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    bundle_t        w_in;
    bundle_t        w_head;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_load;
    logic [31:0]    w_slot0;
    logic [31:0]    w_slot1;
    logic           w_skip0;
    logic           w_skip1;
    logic           w_use_slot1;
    logic           w_last_slot;
    logic           w_unused_pc_msb;

    logic           r_ptr;
    logic           r_valid;
    logic           r_overflow;
    logic [31:0]    r_inst;
    logic [31:0]    r_pc;

    assign w_in   = {pc_in, bundle_in};
    assign w_push = ~branch_flag & ~is_empty_bundle(bundle_in);

    bundle_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .din   (w_in),
        .pop   (w_pop),
        .flush (branch_flag),
        .head  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_slot0 = w_head.inst[63:32];
    assign w_slot1 = w_head.inst[31:0];

    // pc_out keeps only pc[30:0]; the MSB shifts out with the slot bit.
    assign w_unused_pc_msb = w_head.pc[31];

`ifdef SKIP_NOP_EN
    assign w_skip0 = is_nop(w_slot0);
    assign w_skip1 = is_nop(w_slot1);
`else
    assign w_skip0 = 1'b0;
    assign w_skip1 = 1'b0;
`endif

    // Empty bundles are never stored, so a skipped slot0 implies slot1 is
    // real; the entry retires once the slot being issued is the last live one.
    assign w_use_slot1 = r_ptr | w_skip0;
    assign w_last_slot = w_use_slot1 | w_skip1;

    assign w_load = ~stall_in | ~r_valid;
    assign w_pop  = w_load & ~w_empty & w_last_slot & ~branch_flag;

    assign interlock = (w_count >= CW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr   <= 1'b0;
            r_valid <= 1'b0;
            r_inst  <= NOP_WORD;
            r_pc    <= '0;
        end else if (branch_flag) begin
            r_ptr   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            if (w_empty) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= 1'b1;
                r_inst  <= w_use_slot1 ? w_slot1 : w_slot0;
                r_pc    <= {w_head.pc[30:0], w_use_slot1};
                r_ptr   <= ~w_last_slot;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_push & w_full & ~w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign inst_out  = r_inst;
    assign pc_out    = r_pc;
    assign valid_out = r_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_bundle_issue.sv
module tb_bundle_issue;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_in;
    logic [63:0] bundle_in;
    logic        branch_flag;
    logic        stall_in;
    logic        interlock;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        overflow;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    always #5 clk = ~clk;

    bundle_issue #(.DEPTH(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pc_in       (pc_in),
        .bundle_in   (bundle_in),
        .branch_flag (branch_flag),
        .stall_in    (stall_in),
        .interlock   (interlock),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .valid_out   (valid_out),
        .overflow    (overflow)
    );

    localparam logic [31:0] IA = 32'h0000_0113;
    localparam logic [31:0] IB = 32'h0020_8233;
    localparam logic [31:0] IC = 32'h0041_0313;
    localparam logic [31:0] ID = 32'h00c0_006f;
    localparam logic [31:0] IE = 32'h0010_0093;
    localparam logic [31:0] IF = 32'h0020_0113;
    localparam logic [31:0] IG = 32'h0031_8193;
    localparam logic [31:0] IH = 32'h4000_0033;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] b;
        int unsigned n;
        logic [31:0] i0;
        logic [31:0] p0;
        logic [31:0] i1;
        logic [31:0] p1;
    } vec_t;

    localparam int unsigned NV = 6;
    vec_t tbl [NV];

    exp_t sb [$];
    exp_t mon_e;
    bit   mon_en  = 1'b0;
    logic last_il = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [63:0] b, input logic br, input logic st);
        pc_in       = pc;
        bundle_in   = b;
        branch_flag = br;
        stall_in    = st;
    endtask

    task automatic idle();
        drive(32'h0, {NOP_WORD, NOP_WORD}, 1'b0, 1'b0);
    endtask

    // Scoreboard consumer: an instruction is taken at the next edge when it
    // is valid and downstream is not stalling.
    always @(negedge clk) begin
        last_il = interlock;
        if (mon_en && rstn && !branch_flag && valid_out && !stall_in) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL extra_issue: got inst %h pc %h, required no issue", inst_out, pc_out);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_inst", inst_out, mon_e.inst);
                chk("sb_pc", pc_out, mon_e.pc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'd5, {IA, IB}, 2, IA, 32'd10, IB, 32'd11};
`ifdef SKIP_NOP_EN
        tbl[1] = '{32'd3, {NOP_WORD, IC}, 1, IC, 32'd7, 32'h0, 32'h0};
        tbl[2] = '{32'h8000_0010, {ID, NOP_WORD}, 1, ID, 32'h20, 32'h0, 32'h0};
`else
        tbl[1] = '{32'd3, {NOP_WORD, IC}, 2, NOP_WORD, 32'd6, IC, 32'd7};
        tbl[2] = '{32'h8000_0010, {ID, NOP_WORD}, 2, ID, 32'h20, NOP_WORD, 32'h21};
`endif
        tbl[3] = '{32'h12, {NOP_WORD, NOP_WORD}, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4] = '{32'h7fff_ffff, {IE, IF}, 2, IE, 32'hffff_fffe, IF, 32'hffff_ffff};
        tbl[5] = '{32'h100, {IG, IH}, 2, IG, 32'h200, IH, 32'h201};

        // Reset state
        rstn = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_inst", inst_out, NOP_WORD);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_interlock", 32'(interlock), 32'h0);
        rstn = 1'b1;

        // Basic issue order and latency
        drive(32'd5, {IA, IB}, 1'b0, 1'b0);
        tick();
        chk("t2_il_after_write", 32'(interlock), 32'h1);
        chk("t2_valid_before", 32'(valid_out), 32'h0);
        idle();
        tick();
        chk("t2_valid0", 32'(valid_out), 32'h1);
        chk("t2_inst0", inst_out, IA);
        chk("t2_pc0", pc_out, 32'd10);
        tick();
        chk("t2_inst1", inst_out, IB);
        chk("t2_pc1", pc_out, 32'd11);
        tick();
        chk("t2_valid_end", 32'(valid_out), 32'h0);
        chk("t2_il_end", 32'(interlock), 32'h0);

        // NOP slot0
        drive(32'd3, {NOP_WORD, IC}, 1'b0, 1'b0);
        tick();
        idle();
        tick();
`ifdef SKIP_NOP_EN
        chk("t5_inst", inst_out, IC);
        chk("t5_pc", pc_out, 32'd7);
`else
        chk("t5_inst_nop", inst_out, NOP_WORD);
        chk("t5_pc_nop", pc_out, 32'd6);
        chk("t5_valid_nop", 32'(valid_out), 32'h1);
        tick();
        chk("t5_inst", inst_out, IC);
        chk("t5_pc", pc_out, 32'd7);
`endif
        tick();
        chk("t5_valid_end", 32'(valid_out), 32'h0);

        // Fill under stall, then force overflow
        drive(32'd1, {IA, IB}, 1'b0, 1'b1);
        tick();
        chk("t3_il1", 32'(interlock), 32'h1);
        chk("t3_ovf1", 32'(overflow), 32'h0);
        drive(32'd2, {IC, ID}, 1'b0, 1'b1);
        tick();
        chk("t3_ovf2", 32'(overflow), 32'h0);
        chk("t3_il2", 32'(interlock), 32'h1);
        chk("t3_inst2", inst_out, IA);
        chk("t3_pc2", pc_out, 32'd2);
        drive(32'd3, {IE, IF}, 1'b0, 1'b1);
        tick();
        chk("t3_ovf3", 32'(overflow), 32'h1);
        chk("t3_hold_inst", inst_out, IA);
        chk("t3_hold_pc", pc_out, 32'd2);
        chk("t3_hold_valid", 32'(valid_out), 32'h1);

        // Branch flush with entries queued, bundle on input, stall high
        drive(32'd4, {IG, IH}, 1'b1, 1'b1);
        tick();
        chk("t4_valid", 32'(valid_out), 32'h0);
        chk("t4_il", 32'(interlock), 32'h0);
        chk("t4_ovf_sticky", 32'(overflow), 32'h1);
        idle();
        tick();
        tick();
        chk("t4_no_leftover", 32'(valid_out), 32'h0);

        // Empty bundle is never written
        drive(32'd7, {NOP_WORD, NOP_WORD}, 1'b0, 1'b0);
        tick();
        chk("t6_il", 32'(interlock), 32'h0);
        idle();
        tick();
        chk("t6_valid", 32'(valid_out), 32'h0);

        // Reset mid-stream with two entries buffered
        drive(32'd8, {IA, IB}, 1'b0, 1'b1);
        tick();
        drive(32'd9, {IC, ID}, 1'b0, 1'b1);
        tick();
        chk("t1_il_full", 32'(interlock), 32'h1);
        rstn = 1'b0;
        idle();
        #2;
        chk("t1_valid", 32'(valid_out), 32'h0);
        chk("t1_il", 32'(interlock), 32'h0);
        chk("t1_ovf", 32'(overflow), 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("t1_valid_after", 32'(valid_out), 32'h0);
        chk("t1_il_after", 32'(interlock), 32'h0);

        // Table-driven stream with fetch obeying interlock and random stalls
        sb.delete();
        mon_en = 1'b1;
        begin
            int unsigned idx   = 0;
            int unsigned guard = 0;
            vec_t v;
            exp_t e;
            while (idx < 3 * NV && guard < 2000) begin
                guard++;
                stall_in    = ($urandom_range(0, 3) == 0);
                branch_flag = 1'b0;
                if (last_il) begin
                    pc_in     = 32'h0;
                    bundle_in = {NOP_WORD, NOP_WORD};
                end else begin
                    v         = tbl[idx % NV];
                    pc_in     = v.pc;
                    bundle_in = v.b;
                    if (v.n > 0) begin
                        e.inst = v.i0;
                        e.pc   = v.p0;
                        sb.push_back(e);
                    end
                    if (v.n > 1) begin
                        e.inst = v.i1;
                        e.pc   = v.p1;
                        sb.push_back(e);
                    end
                    idx++;
                end
                tick();
            end
            idle();
            guard = 0;
            while (sb.size() != 0 && guard < 200) begin
                guard++;
                tick();
            end
        end
        chk("stream_drained", 32'(sb.size()), 32'h0);
        tick();
        tick();
        mon_en = 1'b0;
        chk("stream_valid_end", 32'(valid_out), 32'h0);
        chk("stream_no_overflow", 32'(overflow), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
